// File: rtl/matrix_pkg.sv
// Shared types and sizes for the 2x2 matrix multiplier result path.
package matrix_pkg;

   localparam int unsigned ELEM_W   = 8;
   localparam int unsigned ELEMS    = 4;
   localparam int unsigned RESULT_W = ELEM_W * ELEMS;

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_e;

   typedef logic [1:0] elem_idx_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous word FIFO; head word is presented combinationally on rdata_o.
module result_fifo #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESULT_W = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic [RESULT_W-1:0]       wdata_i,
   output logic [RESULT_W-1:0]       rdata_o,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      full_o,
   output logic                      empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [RESULT_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]       wr_q, rd_q;
   logic [LW-1:0]       level_q;
   logic                push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];
   assign level_o = level_q;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_q] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (push_ok) begin
            wr_q <= wr_q + AW'(1);
         end
         if (pop_ok) begin
            rd_q <= rd_q + AW'(1);
         end
         level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
      end
   end

endmodule

// File: rtl/matrix_result_serializer.sv
// Buffers matrix_result words and streams them out one element per byte
// over valid/ready, flagging any word dropped on a full buffer.
module matrix_result_serializer
   import matrix_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [RESULT_W-1:0]     matrix_result,
   input  logic                    result_valid,
   output logic                    result_ready,
   output logic [ELEM_W-1:0]       byte_out,
   output logic                    byte_valid,
   input  logic                    byte_ready,
   output logic                    byte_last,
   output logic                    overflow,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   localparam elem_idx_t LAST = elem_idx_t'(ELEMS - 1);

   logic [RESULT_W-1:0] head;
   logic                full, empty, pop;

   ser_state_e          state_q, state_d;
   elem_idx_t           idx_q, idx_d, nxt_idx;
   logic [RESULT_W-1:0] shift_q, shift_d;
   logic [ELEM_W-1:0]   byte_q, byte_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                ovf_q, ovf_d;

   result_fifo #(
      .DEPTH    (DEPTH),
      .RESULT_W (RESULT_W)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (result_valid),
      .pop_i   (pop),
      .wdata_i (matrix_result),
      .rdata_o (head),
      .level_o (fifo_level),
      .full_o  (full),
      .empty_o (empty)
   );

   assign result_ready = !full;
   assign byte_out     = byte_q;
   assign byte_valid   = valid_q;
   assign byte_last    = last_q;
   assign overflow     = ovf_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      last_d  = last_q;
      pop     = 1'b0;
      nxt_idx = idx_q + 2'd1;
      ovf_d   = ovf_q | (result_valid & full);

      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               idx_d   = '0;
               byte_d  = head[ELEM_W-1:0];
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (byte_ready) begin
               if (idx_q != LAST) begin
                  shift_d = shift_q >> ELEM_W;
                  idx_d   = nxt_idx;
                  byte_d  = shift_q[2*ELEM_W-1:ELEM_W];
                  last_d  = (nxt_idx == LAST);
               end else if (!empty) begin
                  // chain straight into the next word so the stream has no bubble
                  pop     = 1'b1;
                  shift_d = head;
                  idx_d   = '0;
                  byte_d  = head[ELEM_W-1:0];
                  last_d  = 1'b0;
               end else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  idx_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer: accepted words queue their
// bytes, and every accepted output byte is popped and compared.
module tb_matrix_result_serializer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] matrix_result;
   logic        result_valid;
   logic        result_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;
   logic        overflow;
   logic [2:0]  fifo_level;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [9:0]  sb_q [$];

   always #5 clock = ~clock;

   matrix_result_serializer #(.DEPTH(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .matrix_result (matrix_result),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .byte_out      (byte_out),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .byte_last     (byte_last),
      .overflow      (overflow),
      .fifo_level    (fifo_level)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Monitor: sampled on the falling edge, half a cycle away from the active edge.
   always @(negedge clock) begin
      logic [9:0] exp;
      if (!reset) begin
         sb_q.delete();
      end else begin
         if (byte_valid && byte_ready) begin
            exp = 10'h3FF;
            if (sb_q.size() > 0) exp = sb_q.pop_front();
            check_eq("byte", {22'd0, 1'b0, byte_last, byte_out}, {22'd0, exp});
         end
         if (result_valid && result_ready) begin
            for (int k = 0; k < 4; k++) begin
               sb_q.push_back({1'b0, (k == 3), matrix_result[8*k +: 8]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      matrix_result = w;
      result_valid  = 1'b1;
      tick();
      result_valid  = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 80; c++) begin
         if (sb_q.size() == 0 && !byte_valid) break;
         tick();
      end
      check_eq(tag, sb_q.size(), 0);
      check_eq({tag, "_valid"}, byte_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      matrix_result = '0;
      result_valid  = 1'b0;
      byte_ready    = 1'b1;
      tick();
      tick();
      check_eq("rst_byte_out", byte_out, 0);
      check_eq("rst_valid", byte_valid, 0);
      check_eq("rst_last", byte_last, 0);
      check_eq("rst_overflow", overflow, 0);
      check_eq("rst_level", fifo_level, 0);
      check_eq("rst_ready", result_ready, 1);
      reset = 1'b1;
      tick();

      // single word, latency and contiguity
      push_word(32'h0805140D);
      check_eq("lat_valid_n", byte_valid, 0);
      check_eq("lat_level_n", fifo_level, 1);
      tick();
      check_eq("lat_valid_n1", byte_valid, 1);
      check_eq("lat_byte0", byte_out, 8'h0D);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("single_contig", byte_valid, 1);
      end
      tick();
      check_eq("single_done_valid", byte_valid, 0);
      check_eq("single_done_level", fifo_level, 0);

      // backpressure on element 1
      push_word(32'h0805140D);
      tick();
      tick();
      byte_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_byte", byte_out, 8'h14);
         check_eq("bp_valid", byte_valid, 1);
         tick();
      end
      byte_ready = 1'b1;
      drain("bp_drain");

      // back-to-back words
      push_word(32'h44332211);
      push_word(32'h88776655);
      for (int i = 0; i < 8; i++) begin
         check_eq("b2b_contig", byte_valid, 1);
         tick();
      end
      check_eq("b2b_end", byte_valid, 0);
      drain("b2b_drain");

      // overflow with consumer stalled
      byte_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         push_word(32'hA0A1A2A3 + 32'h10101010 * i);
         if (i == 4) begin
            check_eq("ovf_level_full", fifo_level, 4);
            check_eq("ovf_ready_low", result_ready, 0);
            check_eq("ovf_not_yet", overflow, 0);
         end
      end
      check_eq("ovf_set", overflow, 1);
      check_eq("ovf_level_kept", fifo_level, 4);
      byte_ready = 1'b1;
      drain("ovf_drain");
      check_eq("ovf_sticky", overflow, 1);

      // reset mid-word
      push_word(32'h0805140D);
      tick();
      tick();
      check_eq("mid_byte1", byte_out, 8'h14);
      reset = 1'b0;
      tick();
      check_eq("mid_rst_valid", byte_valid, 0);
      check_eq("mid_rst_level", fifo_level, 0);
      check_eq("mid_rst_ovf", overflow, 0);
      reset = 1'b1;
      push_word(32'hDDCCBBAA);
      tick();
      check_eq("mid_fresh_byte0", byte_out, 8'hAA);
      drain("mid_drain");

      // same-edge push and pop at level 2
      push_word(32'h13121110);
      push_word(32'h23222120);
      push_word(32'h33323130);
      tick();
      tick();
      check_eq("pp_level_before", fifo_level, 2);
      check_eq("pp_last_shown", byte_last, 1);
      push_word(32'h43424140);
      check_eq("pp_level_after", fifo_level, 2);
      check_eq("pp_no_bubble", byte_valid, 1);
      check_eq("pp_next_byte0", byte_out, 8'h20);
      drain("pp_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
